// File: rtl/piso_if.sv
// Load handshake, shift enable and serial output bundle for the piso transmitter.
interface piso_if #(
  parameter int WIDTH = 8
);
  logic             shift_en;
  logic [WIDTH-1:0] parallel_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output shift_en, parallel_in, load_valid,
    input  load_ready, serial_out, serial_valid, busy, frame_done
  );

  modport slave (
    input  shift_en, parallel_in, load_valid,
    output load_ready, serial_out, serial_valid, busy, frame_done
  );
endinterface

// File: rtl/piso.sv
// Parallel-in/serial-out transmitter with a one-word holding register so
// consecutive frames stream with no idle bit between them.
module piso #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  piso_if.slave   bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] hold_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             hold_full;
  logic             frame_done_q;

  logic xfer;
  logic last_edge;

  function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] r);
    if (MSB_FIRST) shift_next = {r[WIDTH-2:0], 1'b0};
    else           shift_next = {1'b0, r[WIDTH-1:1]};
  endfunction

  assign xfer      = bus.load_valid && !hold_full;
  assign last_edge = (state == SHIFT) && bus.shift_en && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shift_reg    <= '0;
      hold_reg     <= '0;
      bit_cnt      <= '0;
      hold_full    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_edge;
      case (state)
        IDLE: begin
          if (xfer) begin
            shift_reg <= bus.parallel_in;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // A load on the last-bit edge (hold necessarily empty) bypasses the
          // holding register and becomes the next frame directly.
          if (xfer && !last_edge) begin
            hold_reg  <= bus.parallel_in;
            hold_full <= 1'b1;
          end
          if (bus.shift_en) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (hold_full) begin
                shift_reg <= hold_reg;
                hold_full <= 1'b0;
              end else if (xfer) begin
                shift_reg <= bus.parallel_in;
              end else begin
                state <= IDLE;
              end
            end else begin
              shift_reg <= shift_next(shift_reg);
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready   = !hold_full;
  assign bus.serial_valid = (state == SHIFT);
  assign bus.serial_out   = (state == SHIFT) &&
                            (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
  assign bus.busy         = (state == SHIFT) || hold_full;
  assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_piso.sv
// Directed table-driven bench for piso plus hand-written stall/reset/loopback sequences.
module tb_piso;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_if #(.WIDTH(8)) bus ();
  piso_if #(.WIDTH(8)) bus_l ();

  piso #(.WIDTH(8), .MSB_FIRST(1'b1)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
  piso #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

  typedef struct {
    logic       se;
    logic       lv;
    logic [7:0] pin;
    logic       so;
    logic       sv;
    logic       bz;
    logic       lr;
    logic       fd;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Receiver model standing in for sipo on the loopback path.
  logic       rx_en = 1'b0;
  logic [7:0] rx_sh = '0;
  int         rx_cnt = 0;
  logic [7:0] rx_words[$];

  always @(posedge clk) begin
    if (!rx_en || rst) begin
      rx_cnt <= 0;
    end else if (bus.shift_en && bus.serial_valid) begin
      rx_sh <= {rx_sh[6:0], bus.serial_out};
      if (rx_cnt == 7) begin
        rx_words.push_back({rx_sh[6:0], bus.serial_out});
        rx_cnt <= 0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic se, input logic lv, input logic [7:0] pin,
                     input logic so, input logic sv, input logic bz,
                     input logic lr, input logic fd);
    vec_t v;
    v.se = se; v.lv = lv; v.pin = pin;
    v.so = so; v.sv = sv; v.bz = bz; v.lr = lr; v.fd = fd;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic so, input logic sv,
                            input logic bz, input logic lr, input logic fd);
    chk({tag, " serial_out"},   bus.serial_out,   so);
    chk({tag, " serial_valid"}, bus.serial_valid, sv);
    chk({tag, " busy"},         bus.busy,         bz);
    chk({tag, " load_ready"},   bus.load_ready,   lr);
    chk({tag, " frame_done"},   bus.frame_done,   fd);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] w2;

    bus.shift_en = 1'b0; bus.load_valid = 1'b0; bus.parallel_in = '0;
    bus_l.shift_en = 1'b0; bus_l.load_valid = 1'b0; bus_l.parallel_in = '0;
    rst = 1'b1;
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single frame 0xAA
    w = 8'hAA;
    add(1, 1, w, 0, 0, 0, 1, 0);
    for (int k = 7; k >= 0; k--) add(1, 0, 8'h00, w[k], 1, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 1);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0);

    // 0xAA then 0xCC through the hold register; a load while full is ignored
    w = 8'hAA; w2 = 8'hCC;
    add(1, 1, w, 0, 0, 0, 1, 0);
    for (int k = 7; k >= 0; k--) begin
      if (k == 7)      add(1, 1, w2,    w[k], 1, 1, 1, 0);
      else if (k == 5) add(1, 1, 8'hFF, w[k], 1, 1, 0, 0);
      else             add(1, 0, 8'h00, w[k], 1, 1, 0, 0);
    end
    for (int k = 7; k >= 0; k--) add(1, 0, 8'h00, w2[k], 1, 1, 1, (k == 7));
    add(1, 0, 8'h00, 0, 0, 0, 1, 1);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0);

    // 0xF0 with a 3-cycle shift_en stall after bit 2: 11 cycles total
    add(1, 1, 8'hF0, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 1, 1, 1, 1, 0);
    add(1, 0, 8'h00, 1, 1, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 8'h00, 1, 1, 1, 1, 0);
    add(1, 0, 8'h00, 1, 1, 1, 1, 0);
    add(1, 0, 8'h00, 1, 1, 1, 1, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 8'h00, 0, 1, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 1);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0);

    // Load on the last-bit edge with hold empty: 0x81 then 0x7E gapless
    w = 8'h81; w2 = 8'h7E;
    add(1, 1, w, 0, 0, 0, 1, 0);
    for (int k = 7; k >= 0; k--) add(1, (k == 0), (k == 0) ? w2 : 8'h00, w[k], 1, 1, 1, 0);
    for (int k = 7; k >= 0; k--) add(1, 0, 8'h00, w2[k], 1, 1, 1, (k == 7));
    add(1, 0, 8'h00, 0, 0, 0, 1, 1);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.shift_en    = vecs[i].se;
      bus.load_valid  = vecs[i].lv;
      bus.parallel_in = vecs[i].pin;
      #1;
      check_outs($sformatf("row%0d", i), vecs[i].so, vecs[i].sv,
                 vecs[i].bz, vecs[i].lr, vecs[i].fd);
    end

    // Reset mid-frame of 0x55 with 0x12 held, then a clean 0x3C frame
    w = 8'h55;
    @(negedge clk);
    bus.shift_en = 1'b1; bus.load_valid = 1'b1; bus.parallel_in = w;
    for (int k = 7; k >= 4; k--) begin
      @(negedge clk);
      bus.load_valid  = (k == 7);
      bus.parallel_in = (k == 7) ? 8'h12 : 8'h00;
      #1;
      chk($sformatf("pre-rst bit%0d", k), bus.serial_out, w[k]);
    end
    @(negedge clk);
    #1;
    chk("pre-rst load_ready", bus.load_ready, 1'b0);
    rst = 1'b1;
    #1;
    check_outs("mid-rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("post-rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    w = 8'h3C;
    @(negedge clk);
    bus.load_valid = 1'b1; bus.parallel_in = w;
    for (int k = 7; k >= 0; k--) begin
      @(negedge clk);
      bus.load_valid = 1'b0; bus.parallel_in = '0;
      #1;
      chk($sformatf("3C bit%0d", k), bus.serial_out, w[k]);
      chk($sformatf("3C valid%0d", k), bus.serial_valid, 1'b1);
      chk($sformatf("3C fd%0d", k), bus.frame_done, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("3C frame_done", bus.frame_done, 1'b1);
    chk("3C idle busy", bus.busy, 1'b0);

    // LSB-first instance
    w = 8'hCC;
    @(negedge clk);
    bus_l.shift_en = 1'b1; bus_l.load_valid = 1'b1; bus_l.parallel_in = w;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus_l.load_valid = 1'b0;
      #1;
      chk($sformatf("lsb bit%0d", k), bus_l.serial_out, w[k]);
    end
    @(negedge clk);
    #1;
    chk("lsb frame_done", bus_l.frame_done, 1'b1);

    // Loopback into the receiver model: 0xAA then 0xCC
    rx_en = 1'b1;
    @(negedge clk);
    bus.shift_en = 1'b1; bus.load_valid = 1'b1; bus.parallel_in = 8'hAA;
    @(negedge clk);
    bus.parallel_in = 8'hCC;
    @(negedge clk);
    bus.load_valid = 1'b0; bus.parallel_in = '0;
    repeat (20) @(negedge clk);
    checks++;
    if (rx_words.size() != 2) begin
      errors++;
      $display("FAIL loopback count: got %0d expected 2", rx_words.size());
    end
    if (rx_words.size() >= 2) begin
      chk8("loopback word0", rx_words[0], 8'hAA);
      chk8("loopback word1", rx_words[1], 8'hCC);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso.md
# piso

Parallel-in/serial-out transmitter, the send-side counterpart of the `sipo` receiver in the shift-register library. Accepts WIDTH-bit words through a valid/ready load handshake and shifts them out one bit per enabled clock. A one-word holding register lets the next word be accepted mid-frame, so frames stream back-to-back with no idle bit. With `shift_en` shared and MSB-first order, the output drives a `sipo` directly.

## Interface
- `WIDTH`, 8: word length in bits; legal range is 2 and above.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first (matches `sipo`); 0 sends bit 0 first.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `shift_en`  in  1  advance one bit on this edge when a frame is active.
- `parallel_in`  in  WIDTH  word to transmit.
- `load_valid`  in  1  `parallel_in` is valid.
- `load_ready`  out  1  block can accept a word; transfer occurs on an edge where both are high.
- `serial_out`  out  1  current bit.
- `serial_valid`  out  1  `serial_out` carries a frame bit.
- `busy`  out  1  a frame is shifting or a word is held.
- `frame_done`  out  1  one-cycle pulse after the last bit of a frame is consumed.

## Operation
- State: IDLE / SHIFT, `shift_reg[WIDTH-1:0]`, `bit_cnt` (clog2(WIDTH) bits), `hold_reg[WIDTH-1:0]`, `hold_full`.
- `load_ready = !hold_full` (combinational).
- Transfer in IDLE: word goes straight to `shift_reg`, `bit_cnt`=0, go to SHIFT. `hold_full` is always 0 in IDLE.
- Transfer in SHIFT: word goes to `hold_reg`, `hold_full`=1. Exception: on the last-bit edge with `hold_full`=0, the word goes directly to `shift_reg` (gapless).
- SHIFT with `shift_en`=1:
  - Not last bit: shift the register toward the output end and increment `bit_cnt`.
  - Last bit (`bit_cnt`==WIDTH-1): next frame source is `hold_reg` if `hold_full` (clear `hold_full`), else the word transferred this edge, else return to IDLE. `bit_cnt` resets to 0.
- `shift_en`=0: `shift_reg`, `bit_cnt` and `serial_out` all hold. Loads are still accepted into the holding register.
- `serial_out` = `shift_reg[WIDTH-1]` (MSB_FIRST=1) or `shift_reg[0]` (MSB_FIRST=0) in SHIFT. It is 0 in IDLE.
- `serial_valid` = (state==SHIFT). `busy` = SHIFT || `hold_full`.
- `frame_done` is registered. It is high for exactly the one cycle after each last-bit edge, including between back-to-back frames.
- `load_valid` without `load_ready` is ignored. `parallel_in` is sampled only on a transfer edge.

## Timing
- Reset values: state IDLE, `shift_reg`/`hold_reg`/`bit_cnt` 0, `hold_full` 0.
- Outputs during and after reset: `serial_out` 0, `serial_valid` 0, `busy` 0, `load_ready` 1, `frame_done` 0.
- Reset mid-frame aborts the current frame and discards the held word. No `frame_done` is issued.
- Load latency: a transfer in IDLE on edge N puts the first bit on `serial_out` with `serial_valid`=1 in the cycle after edge N.
- Each bit is presented before the edge that consumes it. A `sipo` sampling `serial_in` on the same `shift_en` edge captures it.
- With `shift_en` held high, a frame occupies exactly WIDTH cycles.
- Back-to-back frames: the first bit of frame k+1 directly follows the last bit of frame k, and `serial_valid` never drops.
- Simultaneous load and last bit with hold empty: the new word becomes the next frame with no gap, and `hold_full` stays 0.
- Hold full: `load_ready` is low from the edge after the hold load until the last-bit edge of the current frame.

## Test plan
- Reset, then load 0xAA with `shift_en`=1 continuously -> `serial_out` = 1,0,1,0,1,0,1,0 over 8 cycles with `serial_valid`=1. `frame_done` pulses once. The block returns to IDLE with `busy`=0.
- Load 0xAA, then 0xCC during the first frame -> 16 consecutive valid bits 10101010_11001100 with no gap. `load_ready` is low from after the 0xCC load until the 0xAA last bit. `frame_done` pulses twice, 8 cycles apart.
- Load 0xF0 and drop `shift_en` for 3 cycles after bit 2 -> `serial_out` holds at 1 for the stall. The full sequence 11110000 completes in 11 cycles.
- MSB_FIRST=0, load 0xCC -> `serial_out` = 0,0,1,1,0,0,1,1.
- Assert `rst` after bit 4 of 0x55 with a word held -> all outputs return to reset values immediately and `load_ready`=1. The next load of 0x3C transmits 00111100 cleanly.
- Loopback into `sipo` with shared `clk`/`rst`/`shift_en`, sending 0xAA then 0xCC -> `parallel_out` shows 0xAA then 0xCC, each with `data_valid` asserted.
